// File: rtl/fifo_pkg.sv
// Shared sizing defaults and the saturating drop-counter helper for param_fifo.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 63;
    localparam int FIFO_DEPTH_DEF = 2048;
    localparam int FIFO_BITS_DEF  = 11;
    localparam int DROP_COUNT_W   = 16;

    typedef logic [DROP_COUNT_W-1:0] drop_count_t;

    function automatic drop_count_t drop_count_inc(input drop_count_t value);
        return (value == '1) ? value : value + drop_count_t'(1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read with read enable, no reset.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int ADDR_W = FIFO_BITS_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// threshold flags, sticky error flags and a saturating count of dropped writes.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int FIFO_BITS  = FIFO_BITS_DEF,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [FIFO_WIDTH-1:0]   data_in,
    input  logic                    write_n,
    input  logic                    read_n,
    input  logic [FIFO_BITS:0]      af_thresh,
    input  logic [FIFO_BITS:0]      ae_thresh,
    input  logic                    clear_flags,
    output logic [FIFO_WIDTH-1:0]   data_out,
    output logic [FIFO_BITS:0]      fifo_counter,
    output logic                    fifo_full,
    output logic                    fifo_half,
    output logic                    fifo_empty,
    output logic                    fifo_almost_full,
    output logic                    fifo_almost_empty,
    output logic                    overflow,
    output logic                    underflow,
    output logic [DROP_COUNT_W-1:0] drop_count
);

    localparam logic [FIFO_BITS:0]   FULL_COUNT = (FIFO_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_BITS:0]   HALF_COUNT = (FIFO_BITS+1)'(FIFO_DEPTH / 2);
    localparam logic [FIFO_BITS:0]   COUNT_ONE  = (FIFO_BITS+1)'(1);
    localparam logic [FIFO_BITS-1:0] PTR_ONE    = FIFO_BITS'(1);

    logic [FIFO_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_BITS:0]    count_q, count_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    drop_count_t           drop_count_q, drop_count_d;

    logic                  wr_accept, rd_accept;
    logic                  wr_reject, rd_reject;
    logic                  ram_rd_en;
    logic [FIFO_BITS:0]    ram_count;
    logic [FIFO_WIDTH-1:0] ram_rd_data;

    // out_valid means "the RAM read register holds a word that belongs on data_out";
    // in FWFT mode it is the staging-valid bit that the prefetch keeps topped up.
    always_comb begin
        wr_accept = !write_n && !fifo_full;
        rd_accept = !read_n && !fifo_empty;
        wr_reject = !write_n && fifo_full;
        rd_reject = !read_n && fifo_empty;
        ram_count = count_q - (FIFO_BITS+1)'(out_valid_q);

        if (FWFT != 0) begin
            ram_rd_en   = (ram_count != '0) && (!out_valid_q || rd_accept);
            out_valid_d = ram_rd_en || (out_valid_q && !rd_accept);
        end else begin
            ram_rd_en   = rd_accept;
            out_valid_d = out_valid_q || rd_accept;
        end

        wr_ptr_d = wr_accept ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = ram_rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        count_d = count_q;
        if (wr_accept && !rd_accept) begin
            count_d = count_q + COUNT_ONE;
        end else if (rd_accept && !wr_accept) begin
            count_d = count_q - COUNT_ONE;
        end

        overflow_d   = overflow_q && !clear_flags;
        underflow_d  = underflow_q && !clear_flags;
        drop_count_d = clear_flags ? '0 : drop_count_q;
        if (wr_reject) begin
            overflow_d   = 1'b1;
            drop_count_d = drop_count_inc(drop_count_d);
        end
        if (rd_reject) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    fifo_ram #(
        .WIDTH  (FIFO_WIDTH),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (FIFO_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset, so data_out is masked until it holds a real word.
    assign data_out          = out_valid_q ? ram_rd_data : '0;
    assign fifo_counter      = count_q;
    assign fifo_full         = (count_q == FULL_COUNT);
    assign fifo_half         = (count_q >= HALF_COUNT);
    assign fifo_empty        = (FWFT != 0) ? !out_valid_q : (count_q == '0);
    assign fifo_almost_full  = (count_q >= af_thresh);
    assign fifo_almost_empty = (count_q <= ae_thresh);
    assign overflow          = overflow_q;
    assign underflow         = underflow_q;
    assign drop_count        = drop_count_q;

endmodule

// File: tb/tb_param_fifo.sv
// Drives one registered-read and one FWFT param_fifo with identical stimulus and
// checks both against queue-based reference models through a popped-word scoreboard.
module tb_param_fifo;

    localparam int W = 63;
    localparam int D = 2048;
    localparam int B = 11;

    typedef logic [W-1:0] word_t;

    logic           clk;
    logic           reset_n;
    logic           write_n;
    logic           read_n;
    logic           clear_flags;
    word_t          data_in;
    logic [B:0]     af_thresh;
    logic [B:0]     ae_thresh;

    logic [1:0][W-1:0] dout;
    logic [1:0][B:0]   cnt;
    logic [1:0][15:0]  drop;
    logic [1:0]        full, half, empty, afull, aempty, ovf, unf;

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        param_fifo #(
            .FIFO_WIDTH (W),
            .FIFO_DEPTH (D),
            .FIFO_BITS  (B),
            .FWFT       (g)
        ) u_fifo (
            .clk               (clk),
            .reset_n           (reset_n),
            .data_in           (data_in),
            .write_n           (write_n),
            .read_n            (read_n),
            .af_thresh         (af_thresh),
            .ae_thresh         (ae_thresh),
            .clear_flags       (clear_flags),
            .data_out          (dout[g]),
            .fifo_counter      (cnt[g]),
            .fifo_full         (full[g]),
            .fifo_half         (half[g]),
            .fifo_empty        (empty[g]),
            .fifo_almost_full  (afull[g]),
            .fifo_almost_empty (aempty[g]),
            .overflow          (ovf[g]),
            .underflow         (unf[g]),
            .drop_count        (drop[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of held words per DUT; in FWFT mode a word becomes
    // visible on data_out one edge after the edge that wrote it.
    word_t mq0[$];
    word_t mq1[$];
    word_t sb0[$];
    word_t sb1[$];
    bit    m_ovf[2];
    bit    m_unf[2];
    int    m_drop[2];
    bit    vis1;
    word_t exp_out0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        sb0.delete();
        sb1.delete();
        for (int m = 0; m < 2; m++) begin
            m_ovf[m]  = 1'b0;
            m_unf[m]  = 1'b0;
            m_drop[m] = 0;
        end
        vis1     = 1'b0;
        exp_out0 = '0;
    endtask

    task automatic model_step();
        int sz;
        bit is_full, is_empty, wacc, racc;
        for (int m = 0; m < 2; m++) begin
            sz       = (m == 0) ? mq0.size() : mq1.size();
            is_full  = (sz == D);
            is_empty = (m == 0) ? (sz == 0) : !vis1;
            wacc     = !write_n && !is_full;
            racc     = !read_n && !is_empty;
            if (racc) begin
                if (m == 0) begin
                    exp_out0 = mq0.pop_front();
                    sb0.push_back(exp_out0);
                end else begin
                    sb1.push_back(mq1.pop_front());
                end
            end
            if (wacc) begin
                if (m == 0) mq0.push_back(data_in);
                else        mq1.push_back(data_in);
            end
            if (clear_flags) begin
                m_ovf[m]  = 1'b0;
                m_unf[m]  = 1'b0;
                m_drop[m] = 0;
            end
            if (!write_n && is_full) begin
                m_ovf[m] = 1'b1;
                if (m_drop[m] < 65535) m_drop[m]++;
            end
            if (!read_n && is_empty) m_unf[m] = 1'b1;
            if (m == 1) vis1 = (mq1.size() - int'(wacc)) > 0;
        end
    endtask

    task automatic checkOutput();
        int sz;
        logic [6:0] exp_st, act_st;
        for (int m = 0; m < 2; m++) begin
            sz     = (m == 0) ? mq0.size() : mq1.size();
            exp_st = {sz == D, sz >= D / 2, (m == 0) ? (sz == 0) : !vis1,
                      sz >= int'(af_thresh), sz <= int'(ae_thresh), m_ovf[m], m_unf[m]};
            act_st = {full[m], half[m], empty[m], afull[m], aempty[m], ovf[m], unf[m]};
            check($sformatf("dut%0d count", m), 64'(cnt[m]), 64'(sz));
            check($sformatf("dut%0d flags{full,half,empty,af,ae,ovf,unf}", m), 64'(act_st), 64'(exp_st));
            check($sformatf("dut%0d drop_count", m), 64'(drop[m]), 64'(m_drop[m]));
        end
        check("dut0 data_out hold", 64'(dout[0]), 64'(exp_out0));
        if (vis1) check("dut1 data_out head", 64'(dout[1]), 64'(mq1[0]));
    endtask

    task automatic resetCheck();
        model_reset();
        checkOutput();
        check("dut1 data_out reset", 64'(dout[1]), 64'd0);
    endtask

    task automatic applyStimulus(input bit wn, input bit rn, input word_t d, input bit clr);
        @(negedge clk);
        write_n     = wn;
        read_n      = rn;
        data_in     = d;
        clear_flags = clr;
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Monitor: whenever a DUT accepts a pop, compare the word it delivers with the scoreboard.
    logic  fire0, fire1;
    word_t pre1;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            fire0 = reset_n && !read_n && !empty[0];
            fire1 = reset_n && !read_n && !empty[1];
            pre1  = dout[1];
            if (fire1) begin
                check("dut1 scoreboard has word", 64'(sb1.size() != 0), 64'd1);
                if (sb1.size() != 0) check("dut1 popped word", 64'(pre1), 64'(sb1.pop_front()));
            end
            @(posedge clk);
            #1;
            if (fire0) begin
                check("dut0 scoreboard has word", 64'(sb0.size() != 0), 64'd1);
                if (sb0.size() != 0) check("dut0 read word", 64'(dout[0]), 64'(sb0.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit    wn, rn, clr;
        int    wprob, rprob;
        reset_n     = 1'b0;
        write_n     = 1'b1;
        read_n      = 1'b1;
        clear_flags = 1'b0;
        data_in     = '0;
        af_thresh   = (B+1)'(10);
        ae_thresh   = (B+1)'(2);
        #2;
        resetCheck();
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] fill to full, then one rejected write");
        for (int i = 0; i < D; i++) applyStimulus(1'b0, 1'b1, word_t'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, word_t'(32'hDEAD), 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b1);

        $display("[TB] read 1000, write 1000, drain across pointer wrap");
        for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, 1'b1, word_t'(D + i), 1'b0);
        for (int i = 0; i < D; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b1);

        $display("[TB] single word into empty FIFO");
        applyStimulus(1'b0, 1'b1, word_t'(16'h00AB), 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        check("dut1 fwft word visible", 64'(dout[1]), 64'h00AB);
        check("dut1 fwft not empty", 64'(empty[1]), 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);

        $display("[TB] steady read+write at count 5");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, word_t'(100 + i), 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b0, word_t'(200 + i), 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b1);

        $display("[TB] threshold fill 0..11 then asynchronous reset");
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, word_t'(300 + i), 1'b0);
        #2;
        reset_n = 1'b0;
        write_n = 1'b1;
        read_n  = 1'b1;
        #1;
        resetCheck();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int ph = 0; ph < 3; ph++) begin
            wprob = (ph == 0) ? 95 : (ph == 1) ? 10 : 55;
            rprob = (ph == 0) ? 10 : (ph == 1) ? 95 : 50;
            for (int i = 0; i < 3000; i++) begin
                wn  = !($urandom_range(99) < wprob);
                rn  = !($urandom_range(99) < rprob);
                clr = ($urandom_range(63) == 0);
                if ($urandom_range(127) == 0) begin
                    af_thresh = (B+1)'($urandom_range(D));
                    ae_thresh = (B+1)'($urandom_range(D));
                end
                applyStimulus(wn, rn, word_t'({$urandom(), $urandom()}), clr);
            end
        end

        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        check("dut0 scoreboard drained", 64'(sb0.size()), 64'd0);
        check("dut1 scoreboard drained", 64'(sb1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
